cp0_ext: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core, sitting beside the M stage where exceptions and interrupts are resolved. It holds SR, Cause, EPC, PRId and BadVAddr, and optionally Count/Compare. It raises `Req` for the flush/redirect logic and supplies the `eret` return address. It generalises the earlier CP0 to a configurable interrupt-line count, address-fault capture and an on-chip timer interrupt.

---
 rtl/cp0_pkg.sv | 45 ++++
 rtl/cp0_timer.sv | 80 ++++++++
 rtl/cp0_ext.sv | 180 ++++++++++++++++++
 tb/tb_cp0_ext.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
//============================================================================
// Package : cp0_pkg
// Brief   : Shared constants for the MIPS coprocessor-0 slice: register
//           numbers, SR/Cause bit positions and exception codes.
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  // SR / Cause bit positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_TM     = 16;
  localparam int CAUSE_BD  = 31;
  localparam int CAUSE_TI  = 30;
  localparam int IP_LSB    = 10;
  localparam int EXC_LSB   = 2;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // Address-error codes are the only ones that latch BadVAddr
  function automatic logic is_addr_fault(input logic [4:0] code);
    return (code == 5'(EXC_ADEL)) || (code == 5'(EXC_ADES));
  endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
//============================================================================
// Module : cp0_timer
// Brief  : Count/Compare timer with prescaler and timer-interrupt flag (TI).
//          Only instantiated when CP0_TIMER_EN is defined.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module cp0_timer
  import cp0_pkg::*;
#(
  parameter int CNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,     // mtc0 already qualified against Req
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  // Prescaler counts 0..CNT_DIV-1; 8 bits covers the full 1..256 range
  localparam logic [7:0] PRESC_LAST = 8'(CNT_DIV - 1);

  logic [7:0]  presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        wr_count, wr_cmp, tick;

  assign wr_count = wr_en_i && (addr_i == CP0_COUNT);
  assign wr_cmp   = wr_en_i && (addr_i == CP0_COMPARE);
  assign tick     = (presc_q == PRESC_LAST);

  // Next-state: software writes win over the increment; TI only fires when
  // Count actually moves onto Compare, so an idle Count==Compare after reset
  // does not raise a spurious interrupt.
  always_comb begin
    presc_d   = tick ? 8'd0 : presc_q + 8'd1;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (wr_count) begin
      count_d = wdata_i;
      presc_d = 8'd0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end
    if (wr_cmp) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if ((wr_count || tick) && (count_d == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= 8'd0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

`default_nettype wire

// File: rtl/cp0_ext.sv
//============================================================================
// Module : cp0_ext
// Brief  : Coprocessor-0 beside the M stage: SR, Cause, EPC, PRId, BadVAddr
//          and optional Count/Compare timer. Raises Req for flush/redirect
//          and provides the eret return address.
// Config : CP0_TIMER_EN enables Count/Compare, TI, TM and TimerIrq.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID      = 32'h0000_0007,
  parameter int          CNT_DIV   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [31:0]          BadVAddrIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req,
  output logic                 TimerIrq
);

  logic                 ie_q, ie_d;
  logic                 exl_q, exl_d;
  logic [NUM_HWINT-1:0] im_q, im_d;
  logic                 bd_q, bd_d;
  logic [NUM_HWINT-1:0] ip_q, ip_d;
  logic [4:0]           exc_q, exc_d;
  logic [31:0]          epc_q, epc_d;
  logic [31:0]          badva_q, badva_d;

  logic        int_req, exc_req, wr_ok;
  logic        tm, ti;
  logic [31:0] count, compare;
  logic [31:0] sr_rd, cause_rd;

  // A pending exception/interrupt swallows any mtc0 in the same cycle
  assign wr_ok = en && !Req;

`ifdef CP0_TIMER_EN
  logic tm_q;

  // SR.TM lives here because it only exists with the timer
  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q <= 1'b0;
    end else if (wr_ok && (CP0Add == CP0_SR)) begin
      tm_q <= CP0In[SR_TM];
    end
  end

  assign tm = tm_q;

  cp0_timer #(
    .CNT_DIV (CNT_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_ok),
    .addr_i    (CP0Add),
    .wdata_i   (CP0In),
    .count_o   (count),
    .compare_o (compare),
    .ti_o      (ti)
  );
`else
  logic [8:0] unused_cnt_div;

  assign unused_cnt_div = 9'(CNT_DIV);
  assign tm      = 1'b0;
  assign ti      = 1'b0;
  assign count   = 32'd0;
  assign compare = 32'd0;
`endif

  // Request logic is purely combinational so the flush happens this cycle
  assign int_req  = !exl_q && ie_q && ((|(HWInt & im_q)) || (ti && tm));
  assign exc_req  = !exl_q && (ExcCodeIn != 5'd0);
  assign Req      = int_req || exc_req;
  assign TimerIrq = ti && tm;
  assign EPCOut   = {epc_q[31:2], 2'b00};

  // Next-state: mtc0 first, then eret, then exception entry overrides both
  always_comb begin
    ie_d    = ie_q;
    exl_d   = exl_q;
    im_d    = im_q;
    bd_d    = bd_q;
    ip_d    = HWInt;
    exc_d   = exc_q;
    epc_d   = epc_q;
    badva_d = badva_q;
    if (wr_ok && (CP0Add == CP0_SR)) begin
      ie_d  = CP0In[SR_IE];
      exl_d = CP0In[SR_EXL];
      im_d  = CP0In[IP_LSB +: NUM_HWINT];
    end
    if (wr_ok && (CP0Add == CP0_EPC)) begin
      epc_d = CP0In;
    end
    if (EXLClr) begin
      exl_d = 1'b0;
    end
    if (Req) begin
      epc_d = BDIn ? (VPC - 32'd4) : VPC;
      bd_d  = BDIn;
      exl_d = 1'b1;
      exc_d = exc_req ? ExcCodeIn : 5'(EXC_INT);
      if (exc_req && is_addr_fault(ExcCodeIn)) begin
        badva_d = BadVAddrIn;
      end
    end
  end

  // CP0 architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      im_q    <= '0;
      bd_q    <= 1'b0;
      ip_q    <= '0;
      exc_q   <= 5'd0;
      epc_q   <= 32'd0;
      badva_q <= 32'd0;
    end else begin
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      badva_q <= badva_d;
    end
  end

  // Assemble SR and Cause views; unimplemented bits read as zero
  always_comb begin
    sr_rd                          = 32'd0;
    sr_rd[SR_IE]                   = ie_q;
    sr_rd[SR_EXL]                  = exl_q;
    sr_rd[IP_LSB +: NUM_HWINT]     = im_q;
    sr_rd[SR_TM]                   = tm;
    cause_rd                       = 32'd0;
    cause_rd[CAUSE_BD]             = bd_q;
    cause_rd[CAUSE_TI]             = ti;
    cause_rd[IP_LSB +: NUM_HWINT]  = ip_q;
    cause_rd[EXC_LSB +: 5]         = exc_q;
  end

  // mfc0 read mux
  always_comb begin
    case (CP0Add)
      CP0_SR:       CP0Out = sr_rd;
      CP0_CAUSE:    CP0Out = cause_rd;
      CP0_EPC:      CP0Out = epc_q;
      CP0_PRID:     CP0Out = PRID;
      CP0_BADVADDR: CP0Out = badva_q;
      CP0_COUNT:    CP0Out = count;
      CP0_COMPARE:  CP0Out = compare;
      default:      CP0Out = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_ext.sv
//============================================================================
// Module : tb_cp0_ext
// Brief  : Directed self-checking bench for cp0_ext (NUM_HWINT=6, CNT_DIV=2).
// Rev    : 1.0  initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cp0_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] CP0Out;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [31:0] BadVAddrIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] EPCOut;
  logic        Req;
  logic        TimerIrq;

  int checks = 0;
  int errors = 0;

  cp0_ext #(
    .NUM_HWINT (6),
    .PRID      (32'h0000_0007),
    .CNT_DIV   (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .CP0Add     (CP0Add),
    .CP0In      (CP0In),
    .CP0Out     (CP0Out),
    .VPC        (VPC),
    .BDIn       (BDIn),
    .ExcCodeIn  (ExcCodeIn),
    .BadVAddrIn (BadVAddrIn),
    .HWInt      (HWInt),
    .EXLClr     (EXLClr),
    .EPCOut     (EPCOut),
    .Req        (Req),
    .TimerIrq   (TimerIrq)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle inputs 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; CP0Add = a; CP0In = d;
    tick();
    en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    CP0Add = a;
    #1;
    check(tag, CP0Out, exp);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_req"}, {31'd0, Req}, 32'd0);
    check({pfx, "_tirq"}, {31'd0, TimerIrq}, 32'd0);
    check({pfx, "_epcout"}, EPCOut, 32'd0);
    rd(5'd12, 32'd0, {pfx, "_sr"});
    rd(5'd13, 32'd0, {pfx, "_cause"});
    rd(5'd14, 32'd0, {pfx, "_epc"});
    rd(5'd8,  32'd0, {pfx, "_badva"});
    rd(5'd9,  32'd0, {pfx, "_count"});
    rd(5'd11, 32'd0, {pfx, "_compare"});
    rd(5'd15, 32'h0000_0007, {pfx, "_prid"});
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; CP0Add = 5'd0; CP0In = 32'd0; VPC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; BadVAddrIn = 32'd0; HWInt = 6'd0; EXLClr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("rst0");

    // mtc0 SR with IE and all IM bits
    mtc0(5'd12, 32'h0000_FC01);
    rd(5'd12, 32'h0000_FC01, "sr_wr");
    check("sr_noreq", {31'd0, Req}, 32'd0);

    // Hardware interrupt on line 2 from a delay-slot instruction
    HWInt = 6'b000100; VPC = 32'h0000_3004; BDIn = 1'b1;
    #1;
    check("hw_req", {31'd0, Req}, 32'd1);
    tick();
    rd(5'd14, 32'h0000_3000, "hw_epc");
    check("hw_epcout", EPCOut, 32'h0000_3000);
    rd(5'd13, 32'h8000_1000, "hw_cause");
    rd(5'd12, 32'h0000_FC03, "hw_sr_exl");
    check("hw_exl_noreq", {31'd0, Req}, 32'd0);

    // eret
    HWInt = 6'd0; BDIn = 1'b0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret_sr");
    rd(5'd13, 32'h8000_0000, "eret_cause");

    // AdEL with an interrupt also pending and a competing mtc0 EPC
    HWInt = 6'b000100; ExcCodeIn = 5'd4; BadVAddrIn = 32'h0000_1001; VPC = 32'h0000_4000;
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'hDEAD_BEEF;
    #1;
    check("adel_req", {31'd0, Req}, 32'd1);
    tick();
    en = 1'b0; HWInt = 6'd0; ExcCodeIn = 5'd0;
    rd(5'd13, 32'h0000_1010, "adel_cause");
    rd(5'd8,  32'h0000_1001, "adel_badva");
    rd(5'd14, 32'h0000_4000, "adel_epc_nowr");
    rd(5'd12, 32'h0000_FC03, "adel_sr");

    // Exceptions are masked while EXL is set
    ExcCodeIn = 5'd12; VPC = 32'h0000_5000;
    #1;
    check("ov_masked_req", {31'd0, Req}, 32'd0);
    tick();
    ExcCodeIn = 5'd0;
    rd(5'd14, 32'h0000_4000, "ov_masked_epc");
    rd(5'd13, 32'h0000_0010, "ov_masked_cause");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    rd(5'd12, 32'h0000_FC01, "eret2_sr");

    // Cause is read-only, unmapped addresses ignore writes, EPC is writable
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd(5'd13, 32'h0000_0010, "cause_ro");
    mtc0(5'd20, 32'hFFFF_FFFF);
    rd(5'd20, 32'd0, "unmapped");
    mtc0(5'd14, 32'h0000_1237);
    rd(5'd14, 32'h0000_1237, "epc_wr");
    check("epc_wr_out", EPCOut, 32'h0000_1234);

`ifdef CP0_TIMER_EN
    // Timer interrupt: Compare=5, Count=0, prescaler 2 -> 10 clocks
    mtc0(5'd12, 32'h0001_0001);
    rd(5'd12, 32'h0001_0001, "tm_sr");
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (9) tick();
    rd(5'd9, 32'd4, "tmr_cnt4");
    check("tmr_irq_pre", {31'd0, TimerIrq}, 32'd0);
    tick();
    rd(5'd9, 32'd5, "tmr_cnt5");
    check("tmr_irq", {31'd0, TimerIrq}, 32'd1);
    check("tmr_req", {31'd0, Req}, 32'd1);
    rd(5'd13, 32'h4000_0010, "tmr_cause_ti");
    VPC = 32'h0000_6000;
    tick();
    rd(5'd13, 32'h4000_0000, "tmr_taken_cause");
    rd(5'd14, 32'h0000_6000, "tmr_taken_epc");
    check("tmr_taken_noreq", {31'd0, Req}, 32'd0);
    mtc0(5'd11, 32'h0000_0100);
    check("tmr_cmp_clr", {31'd0, TimerIrq}, 32'd0);
    rd(5'd13, 32'h0000_0000, "tmr_cmp_clr_cause");
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;

    // Wrap: Count=0xFFFF_FFFF, Compare=0 fires when Count reaches 0
    mtc0(5'd12, 32'h0001_0000);
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, 32'hFFFF_FFFF, "wrap_cnt_ld");
    check("wrap_irq_pre", {31'd0, TimerIrq}, 32'd0);
    tick();
    tick();
    rd(5'd9, 32'd0, "wrap_cnt0");
    check("wrap_irq", {31'd0, TimerIrq}, 32'd1);
    check("wrap_noreq_ie0", {31'd0, Req}, 32'd0);
    rd(5'd13, 32'h4000_0000, "wrap_cause");
`else
    // Timer absent: Count/Compare/TM read zero and ignore writes
    mtc0(5'd9, 32'h0000_0055);
    mtc0(5'd11, 32'h0000_0066);
    rd(5'd9,  32'd0, "notmr_count");
    rd(5'd11, 32'd0, "notmr_compare");
    mtc0(5'd12, 32'h0001_0001);
    rd(5'd12, 32'h0000_0001, "notmr_sr_tm");
    check("notmr_irq", {31'd0, TimerIrq}, 32'd0);
    rd(5'd13, 32'h0000_0010, "notmr_cause");
`endif

    // Reset mid-operation clears everything
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rst1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
